// File: rtl/alu_seq.sv
// Registered ALU for the 6502-family datapath: single-cycle binary ops plus
// sequential BCD add/subtract that corrects one nibble per clock.
module alu_seq #(
    parameter int DATA_W     = 8,
    parameter bit DECIMAL_EN = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] ai,
    input  logic [DATA_W-1:0] bi,
    input  logic              cin,
    output logic [DATA_W-1:0] add,
    output logic              acr,
    output logic              avr,
    output logic              hc,
    output logic              busy,
    output logic              done
);

    localparam int NIB = DATA_W / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int RW  = DATA_W - 4;

    typedef enum logic {IDLE, DEC} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;

    // Latched decimal operands, shifted right one nibble per step.
    logic [DATA_W-1:0] ai_q, bi_q;
    logic              c_q, sub_q, hc_q, avr_q;
    logic [RW-1:0]     res_q;

    logic [DATA_W:0]   sum_w;
    logic              sum_ovf;
    logic [DATA_W-1:0] bin_res;
    logic              bin_acr, bin_avr, bin_hc;

    logic [3:0]        step_a, step_b;
    logic              step_c, step_sub;
    logic [4:0]        step;

    logic              is_dec, accept, start_dec, bin_wr, last;

    // Returns {carry_out, corrected_nibble} for one BCD digit.
    function automatic logic [4:0] bcd_step(input logic [3:0] a, input logic [3:0] b,
                                            input logic c, input logic sub);
        logic [4:0] t;
        logic [4:0] r;
        t = {1'b0, a} + {1'b0, b} + {4'b0000, c};
        if (!sub)
            r = (t > 5'd9) ? {1'b1, t[3:0] + 4'd6} : {1'b0, t[3:0]};
        else
            r = t[4] ? {1'b1, t[3:0]} : {1'b0, t[3:0] - 4'd6};
        return r;
    endfunction

    always_comb begin
        sum_w   = {1'b0, ai} + {1'b0, bi} + {{DATA_W{1'b0}}, cin};
        sum_ovf = (ai[DATA_W-1] == bi[DATA_W-1]) && (sum_w[DATA_W-1] != ai[DATA_W-1]);
        bin_res = sum_w[DATA_W-1:0];
        bin_acr = sum_w[DATA_W];
        bin_avr = sum_ovf;
        // Carry into bit 4 recovered from the sum bit and both operand bits.
        bin_hc  = sum_w[4] ^ ai[4] ^ bi[4];
        case (op)
            3'b001: begin bin_res = ai & bi; bin_acr = 1'b0; bin_avr = 1'b0; bin_hc = 1'b0; end
            3'b010: begin bin_res = ai | bi; bin_acr = 1'b0; bin_avr = 1'b0; bin_hc = 1'b0; end
            3'b011: begin bin_res = ai ^ bi; bin_acr = 1'b0; bin_avr = 1'b0; bin_hc = 1'b0; end
            3'b100: begin
                bin_res = {cin, ai[DATA_W-1:1]};
                bin_acr = ai[0]; bin_avr = 1'b0; bin_hc = 1'b0;
            end
            3'b101: begin
                bin_res = {ai[DATA_W-2:0], cin};
                bin_acr = ai[DATA_W-1]; bin_avr = 1'b0; bin_hc = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        if (state == IDLE) begin
            step_a   = ai[3:0];
            step_b   = bi[3:0];
            step_c   = cin;
            step_sub = op[0];
        end else begin
            step_a   = ai_q[3:0];
            step_b   = bi_q[3:0];
            step_c   = c_q;
            step_sub = sub_q;
        end
        step = bcd_step(step_a, step_b, step_c, step_sub);
    end

    always_comb begin
        is_dec    = DECIMAL_EN && (op[2:1] == 2'b11);
        accept    = (state == IDLE) && op_valid;
        start_dec = accept && is_dec;
        bin_wr    = accept && !is_dec;
        last      = (state == DEC) && (cnt == CW'(NIB - 1));
        state_nxt = state;
        case (state)
            IDLE:    if (start_dec) state_nxt = DEC;
            DEC:     if (last)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    assign busy = (state == DEC);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt  <= '0;
            add  <= '0;
            acr  <= 1'b0;
            avr  <= 1'b0;
            hc   <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= bin_wr || last;
            if (start_dec)         cnt <= CW'(1);
            else if (last)         cnt <= '0;
            else if (state == DEC) cnt <= cnt + CW'(1);
            if (bin_wr) begin
                add <= bin_res;
                acr <= bin_acr;
                avr <= bin_avr;
                hc  <= bin_hc;
            end else if (last) begin
                add <= {step[3:0], res_q};
                acr <= step[4];
                avr <= avr_q;
                hc  <= hc_q;
            end
        end
    end

    // Decimal working registers; only meaningful while an op is in flight.
    always_ff @(posedge i_clk) begin
        if (start_dec || state == DEC) begin
            ai_q  <= (state == IDLE) ? (ai >> 4) : (ai_q >> 4);
            bi_q  <= (state == IDLE) ? (bi >> 4) : (bi_q >> 4);
            c_q   <= step[4];
            res_q <= RW'({step[3:0], res_q} >> 4);
            if (state == IDLE) begin
                sub_q <= op[0];
                hc_q  <= step[4];
                avr_q <= sum_ovf;
            end
        end
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered ALU for the 6502-family datapath. It generalises the core's single-cycle `add` register to DATA_W bits and adds sequential BCD (decimal-mode) add and subtract, which it corrects one nibble per clock. Inputs are the datapath's AI/BI operands and carry-in. It returns the result and ACR/AVR/half-carry flags to the bus-control and P-register logic, with a busy/done handshake so the sequencer can stretch decimal cycles.

## Interface
- DATA_W, 8: operand/result width; must be a multiple of 4 and ≥ 8.
- DECIMAL_EN, 1: 1 = ops 110/111 perform BCD; 0 = they behave exactly as op 000.
- NIB, DATA_W/4: derived, number of nibbles; not overridable.

- i_clk  in  1  clock; all state changes on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- op_valid  in  1  request; sampled only when busy=0.
- op  in  3  000 SUM, 001 AND, 010 OR, 011 EOR, 100 SR, 101 SL, 110 DSUM, 111 DSUB.
- ai  in  DATA_W  A operand.
- bi  in  DATA_W  B operand; for DSUB the datapath supplies ~operand.
- cin  in  1  carry-in (IADDC); for DSUB, 1 = no borrow.
- add  out  DATA_W  result register.
- acr  out  1  carry out.
- avr  out  1  signed overflow.
- hc  out  1  half carry (out of bit 3).
- busy  out  1  multi-cycle decimal op in progress; requests ignored.
- done  out  1  one-cycle pulse: add/flags updated on the preceding edge.

## Operation
- Reset values: add=0, acr=0, avr=0, hc=0, busy=0, done=0, FSM=IDLE, nibble counter=0.
- FSM states: IDLE, DEC.
  - IDLE, with op_valid and a binary op (or DECIMAL_EN=0): compute and write add and flags; done=1; stay IDLE.
  - IDLE, with op_valid and DSUM/DSUB (DECIMAL_EN=1): latch ai, bi, cin and op; process nibble 0; counter=1; go to DEC.
  - DEC: process nibble[counter]; counter++. When the last nibble completes, write add and flags, done=1, go to IDLE.
- Binary ops:
  - SUM: {acr,add}=ai+bi+cin; avr=(ai[W-1]==bi[W-1])&&(add[W-1]!=ai[W-1]); hc=carry out of bit 3.
  - AND/OR/EOR: bitwise; acr=avr=hc=0.
  - SR: add={cin, ai[W-1:1]}, acr=ai[0]; avr=hc=0.
  - SL: add={ai[W-2:0], cin}, acr=ai[W-1]; avr=hc=0.
- Decimal nibble step (k = 0..NIB-1; c starts at latched cin):
  - t = ai_k + bi_k + c, 5-bit.
  - DSUM: if t>9, then nibble=(t+6) mod 16 and c=1; else nibble=t and c=0.
  - DSUB: if t≥16, then nibble=t mod 16 and c=1; else nibble=(t−6) mod 16 and c=0.
- Decimal flags:
  - acr = final c.
  - hc = c after nibble 0.
  - avr = binary-SUM overflow of the latched ai+bi+cin.
- The partial result is kept in an internal register. add/acr/avr/hc hold their previous values until completion, and hold indefinitely between ops.
- op_valid while busy=1 is ignored, not queued. Operand changes during DEC have no effect (they were latched).
- i_rst during DEC aborts the op: no done pulse, and all outputs return to reset values on that edge.
- Invalid BCD digits (>9) are not trapped; they follow the step formula above.

## Timing
- Binary op accepted at edge N: add/flags valid and done=1 during cycle N→N+1. Throughput is 1 op/cycle.
- Decimal op accepted at edge N:
  - busy=1 from after edge N until after edge N+NIB−1.
  - Result written at edge N+NIB−1; done=1 in the following cycle.
  - DATA_W=8 gives a 2-cycle latency.
- Next op is accepted at the first edge where busy=0. The done cycle is also an accept cycle, so done and a new accept may coincide.
- busy and done are never both 1.

## Test plan
- SUM ai=0x7F, bi=0x01, cin=0 → next cycle add=0x80, avr=1, acr=0, hc=1, done=1, busy stays 0.
- DSUM ai=0x58, bi=0x46, cin=0 (DATA_W=8) → busy 1 cycle, then add=0x04, acr=1, done pulses once 2 edges after accept.
- DSUB ai=0x46, bi=0xED, cin=1 → add=0x34, acr=1. DSUB ai=0x12, bi=0xDE, cin=1 → add=0x91, acr=0.
- SR ai=0x81, cin=1 → add=0xC0, acr=1. SL ai=0x81, cin=0 → add=0x02, acr=1.
- Issue DSUM, then assert op_valid with AND on the busy cycle → AND ignored, DSUM result intact; AND accepted when re-issued on the done cycle.
- Assert i_rst during DEC → no done, add=0, flags 0, busy=0. With DECIMAL_EN=0, DSUM 0x58+0x46 → add=0x9E in 1 cycle.
